// File: rtl/cp0_if.sv
// CP0 bus between the multicycle control/datapath and the coprocessor-0 block.
interface cp0_if;
  logic [4:0]  A;
  logic [31:0] DIn;
  logic [29:0] PC;
  logic [4:0]  HWInt;
  logic        Wen;
  logic        EXLSet;
  logic        EXLClr;
  logic        IntReq;
  logic [29:0] EPC;
  logic [31:0] DOut;

  modport master (
    output A, DIn, PC, HWInt, Wen, EXLSet, EXLClr,
    input  IntReq, EPC, DOut
  );

  modport slave (
    input  A, DIn, PC, HWInt, Wen, EXLSet, EXLClr,
    output IntReq, EPC, DOut
  );
endinterface

// File: rtl/cp0.sv
// Coprocessor-0: SR/Cause/EPC/PrID registers, Count/Compare timer and the
// interrupt request seen by the control FSM. IntReq depends on registers only,
// so device lines reach the FSM one edge after they are sampled.
module cp0 #(
  parameter logic [31:0] PRID = 32'h4C59_0001
) (
  input  logic clk,
  input  logic rst,
  cp0_if.slave bus
);

  localparam logic [4:0] A_COUNT   = 5'd9;
  localparam logic [4:0] A_COMPARE = 5'd11;
  localparam logic [4:0] A_SR      = 5'd12;
  localparam logic [4:0] A_CAUSE   = 5'd13;
  localparam logic [4:0] A_EPC     = 5'd14;
  localparam logic [4:0] A_PRID    = 5'd15;

  logic [5:0]  im;        // SR[15:10]
  logic        exl;       // SR[1]
  logic        ie;        // SR[0]
  logic [4:0]  ip_hw;     // Cause[14:10], sampled device lines
  logic        tp;        // Cause[15], timer pending
  logic [4:0]  exc_code;  // Cause[6:2]
  logic [29:0] epc;
  logic [31:0] count;
  logic [31:0] compare;
  logic        timer_hit;
  logic [31:0] dout;

  // Timer match uses the registered Count and Compare of the current cycle.
  assign timer_hit = (count == compare) && (compare != 32'h0);

  // Register state: device sampling, timer and the prioritised strobe decode.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      im       <= 6'h0;
      exl      <= 1'b0;
      ie       <= 1'b0;
      ip_hw    <= 5'h0;
      tp       <= 1'b0;
      exc_code <= 5'h0;
      epc      <= 30'h0;
      count    <= 32'h0;
      compare  <= 32'h0;
    end else begin
      ip_hw <= bus.HWInt;
      count <= count + 32'd1;
      if (timer_hit) begin
        tp <= 1'b1;
      end
      if (bus.EXLSet) begin
        // Exception entry wins over eret and suppresses the A/DIn write.
        epc      <= bus.PC;
        exl      <= 1'b1;
        exc_code <= 5'h0;
      end else if (bus.EXLClr) begin
        exl <= 1'b0;
      end else if (bus.Wen) begin
        case (bus.A)
          A_SR: begin
            im  <= bus.DIn[15:10];
            exl <= bus.DIn[1];
            ie  <= bus.DIn[0];
          end
          A_EPC:   epc   <= bus.DIn[31:2];
          A_COUNT: count <= bus.DIn;  // overrides this cycle's increment
          A_COMPARE: begin
            compare <= bus.DIn;
            tp      <= 1'b0;          // overrides a same-cycle match
          end
          default: ;                  // Cause, PrID and holes are read-only
        endcase
      end
    end
  end

  assign bus.IntReq = (|({tp, ip_hw} & im)) & ie & ~exl;
  assign bus.EPC    = epc;

  // mfc0 read mux; unmapped addresses read zero.
  always_comb begin
    dout = 32'h0;
    case (bus.A)
      A_COUNT:   dout = count;
      A_COMPARE: dout = compare;
      A_SR:      dout = {16'h0, im, 8'h0, exl, ie};
      A_CAUSE:   dout = {16'h0, tp, ip_hw, 3'h0, exc_code, 2'h0};
      A_EPC:     dout = {epc, 2'b00};
      A_PRID:    dout = PRID;
      default:   dout = 32'h0;
    endcase
  end

  assign bus.DOut = dout;

endmodule
